// File: rtl/btn_debounce_if.sv
// Button conditioning bundle: the raw pin going in and the cleaned-up
// level, event pulses and click counter coming back out.
interface btn_debounce_if;
  logic       btn_usr;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] click_count;

  modport master (
    output btn_usr,
    input  btn_level, press_pulse, release_pulse, long_pulse, click_count
  );

  modport slave (
    input  btn_usr,
    output btn_level, press_pulse, release_pulse, long_pulse, click_count
  );
endinterface

// File: rtl/btn_debounce.sv
// Synchronises, debounces and classifies the raw user button into a clean
// level, single-cycle press/release/long-press pulses and a short-click count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES   = 16000,
  parameter int LONG_PRESS_CYCLES = 8000000,
  parameter bit BTN_ACTIVE_LOW    = 1'b0
) (
  input  logic           clk_16mhz,
  input  logic           rst,
  btn_debounce_if.slave  btn
);

  localparam int DCNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HCNT_W = $clog2(LONG_PRESS_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_MAX = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX = HCNT_W'(LONG_PRESS_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    HELD
  } state_t;

  logic              sync1;
  logic              sync2;
  logic              btn_level;
  logic [DCNT_W-1:0] dcnt;
  logic              accept;
  logic              rise;
  logic              fall;

  // A change is accepted on the edge where the counter would have reached
  // DEBOUNCE_CYCLES; the FSM sees the same decision so its pulses line up
  // with the first cycle the new level is visible.
  assign accept = (sync2 != btn_level) && (dcnt == DCNT_MAX);
  assign rise   = accept &&  sync2;
  assign fall   = accept && !sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values; blocking here would collapse the synchroniser.
  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      dcnt      <= '0;
      btn_level <= 1'b0;
    end else begin
      sync1 <= btn.btn_usr ^ BTN_ACTIVE_LOW;
      sync2 <= sync1;
      if (sync2 == btn_level) begin
        dcnt <= '0;
      end else if (accept) begin
        btn_level <= sync2;
        dcnt      <= '0;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  state_t            state, state_d;
  logic [HCNT_W-1:0] hcnt, hcnt_d;
  logic [7:0]        click_count, click_d;
  logic              press_q, release_q, long_q;
  logic              press_d, release_d, long_d;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    hcnt_d    = hcnt;
    click_d   = click_count;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
          hcnt_d  = '0;
          press_d = 1'b1;
        end
      end
      PRESSED: begin
        // Release is checked first so a release landing on the long
        // threshold still counts as a short click.
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
          click_d   = click_count + 8'd1;
        end else if (hcnt == HCNT_MAX) begin
          state_d = HELD;
          long_d  = 1'b1;
        end else begin
          hcnt_d = hcnt + 1'b1;
        end
      end
      HELD: begin
        if (fall) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_16mhz) begin
    if (rst) begin
      state       <= IDLE;
      hcnt        <= '0;
      click_count <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      state       <= state_d;
      hcnt        <= hcnt_d;
      click_count <= click_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
    end
  end

  assign btn.btn_level     = btn_level;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_pulse    = long_q;
  assign btn.click_count   = click_count;

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce: an active-high and an active-low instance
// driven from per-cycle vector tables and hand-written corner sequences.
module tb_btn_debounce;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic clk_16mhz = 1'b0;
  logic rst       = 1'b1;

  always #5 clk_16mhz = ~clk_16mhz;

  btn_debounce_if bus_h ();
  btn_debounce_if bus_l ();

  btn_debounce #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .BTN_ACTIVE_LOW   (1'b0)
  ) dut_h (
    .clk_16mhz(clk_16mhz),
    .rst      (rst),
    .btn      (bus_h)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LONG),
    .BTN_ACTIVE_LOW   (1'b1)
  ) dut_l (
    .clk_16mhz(clk_16mhz),
    .rst      (rst),
    .btn      (bus_l)
  );

  typedef struct packed {
    logic       btn;
    logic       lvl;
    logic       p;
    logic       r;
    logic       l;
    logic [7:0] c;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   multi_pulse = 0;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance one edge and sample 1 time unit later, well clear of the edge.
  task automatic tick();
    @(posedge clk_16mhz);
    #1;
    if ($countones({bus_h.press_pulse, bus_h.release_pulse, bus_h.long_pulse}) > 1 ||
        $countones({bus_l.press_pulse, bus_l.release_pulse, bus_l.long_pulse}) > 1)
      multi_pulse++;
  endtask

  function automatic logic [11:0] outs_h();
    return {bus_h.btn_level, bus_h.press_pulse, bus_h.release_pulse,
            bus_h.long_pulse, bus_h.click_count};
  endfunction

  function automatic void push(input int n, input logic b, input logic lvl,
                               input logic p, input logic r, input logic l,
                               input logic [7:0] c);
    for (int i = 0; i < n; i++)
      vecs.push_back('{btn: b, lvl: lvl, p: p, r: r, l: l, c: c});
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    bus_h.btn_usr = 1'b0;
    bus_l.btn_usr = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int presses, releases, longs;
    logic [7:0] exp_click;

    bus_h.btn_usr = 1'b1;
    bus_l.btn_usr = 1'b1;

    // Clean press (12 cycles) then release: press at step 5, release at 17.
    push(5, 1, 0, 0, 0, 0, 0);
    push(1, 1, 1, 1, 0, 0, 0);
    push(6, 1, 1, 0, 0, 0, 0);
    push(5, 0, 1, 0, 0, 0, 0);
    push(1, 0, 0, 0, 1, 0, 1);
    push(2, 0, 0, 0, 0, 0, 1);
    // Bounce every 2 cycles never survives the 4-cycle filter.
    for (int k = 0; k < 15; k++) begin
      push(2, 1, 0, 0, 0, 0, 1);
      push(2, 0, 0, 0, 0, 0, 1);
    end
    push(10, 0, 0, 0, 0, 0, 1);
    // 50-cycle hold: press at 5, long exactly 20 later at 25, release at 55.
    push(5, 1, 0, 0, 0, 0, 1);
    push(1, 1, 1, 1, 0, 0, 1);
    push(19, 1, 1, 0, 0, 0, 1);
    push(1, 1, 1, 0, 0, 1, 1);
    push(24, 1, 1, 0, 0, 0, 1);
    push(5, 0, 1, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 1);
    push(4, 0, 0, 0, 0, 0, 1);

    // Button held through reset: everything stays 0 while rst is high.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_outputs", outs_h(), 0);
    end
    check("reset_low_level", bus_l.btn_level, 0);
    rst = 1'b0;
    for (int i = 0; i <= 5; i++) begin
      tick();
      check("held_reset_level", bus_h.btn_level, (i == 5) ? 1 : 0);
      check("held_reset_press", bus_h.press_pulse, (i == 5) ? 1 : 0);
    end

    // Reset mid-press: no release pulse afterwards, click stays cleared.
    tick();
    tick();
    rst = 1'b1;
    bus_h.btn_usr = 1'b0;
    tick();
    check("midpress_reset_outputs", outs_h(), 0);
    tick();
    rst = 1'b0;
    releases = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      releases += int'(bus_h.release_pulse);
    end
    check("midpress_no_release", releases, 0);
    check("midpress_click", bus_h.click_count, 0);

    foreach (vecs[i]) begin
      bus_h.btn_usr = vecs[i].btn;
      tick();
      check($sformatf("vec%0d", i), outs_h(),
            {vecs[i].lvl, vecs[i].p, vecs[i].r, vecs[i].l, vecs[i].c});
    end

    // 256 short clicks: counter steps each time and wraps back to 0.
    do_reset();
    exp_click = 8'd0;
    for (int k = 0; k < 256; k++) begin
      presses  = 0;
      releases = 0;
      longs    = 0;
      for (int i = 0; i < 16; i++) begin
        bus_h.btn_usr = (i < 8);
        tick();
        presses  += int'(bus_h.press_pulse);
        releases += int'(bus_h.release_pulse);
        longs    += int'(bus_h.long_pulse);
      end
      exp_click = exp_click + 8'd1;
      check($sformatf("click%0d_count", k), bus_h.click_count, exp_click);
      check($sformatf("click%0d_pulses", k), {presses[3:0], releases[3:0], longs[3:0]},
            12'h110);
    end
    check("click_wrap", bus_h.click_count, 0);

    // Active-low instance: idle pin=1 reads released; 12-cycle low press.
    check("low_idle_level", bus_l.btn_level, 0);
    for (int i = 0; i < 20; i++) begin
      bus_l.btn_usr = (i >= 12);
      tick();
      check("low_level", bus_l.btn_level, (i >= 5 && i < 17) ? 1 : 0);
      check("low_press", bus_l.press_pulse, (i == 5) ? 1 : 0);
      check("low_release", bus_l.release_pulse, (i == 17) ? 1 : 0);
      check("low_long", bus_l.long_pulse, 0);
    end
    check("low_click", bus_l.click_count, 1);

    check("pulse_exclusive", multi_pulse, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
